bin_to_bcd4: RTL and testbench
==============================

# bin_to_bcd4

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) that sits directly upstream of the 4-digit seven-segment display multiplexer. It turns an unsigned binary value into four packed BCD digits and drives them onto the display's 16-bit `num` input. A start/busy/done handshake controls it, and the result is held stable between conversions so the display never shows partial values.

## Interface
- `WIDTH`, default 14: binary input width; must be ≥14 so 9999 is representable.
- `clk`: input, 1 bit. Single system clock, rising-edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Conversion request; sampled only when `busy`=0.
- `bin`: input, `WIDTH` bits. Unsigned value; sampled on the accepting edge only.
- `bcd`: output, 16 bits. Packed BCD result: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units. Connects to display `num`.
- `busy`: output, 1 bit. High while a conversion is in progress.
- `done`: output, 1 bit. Single-cycle pulse when `bcd` updates.
- `ovf`: output, 1 bit. Set when the last converted `bin` exceeded 9999.

## Operation
- Two-state FSM, IDLE and SHIFT, plus a down-counter `cnt`; `cnt` is $clog2(WIDTH+1) bits wide.
- IDLE, when `start`=1:
  - load shift register ← `bin`;
  - clear the 16-bit scratch BCD register;
  - `cnt` ← `WIDTH`;
  - register `ovf_next` = (`bin` > 9999);
  - `busy` ← 1; go to SHIFT.
- SHIFT, each cycle:
  - every scratch digit ≥5 gets +3 (4-bit, no carry out);
  - then shift {scratch, shiftreg} left by 1;
  - `cnt` ← `cnt`−1.
- SHIFT exit: on the edge where `cnt` goes 1→0:
  - `bcd` ← corrected result, or 16'h9999 if `ovf_next`;
  - `ovf` ← `ovf_next`;
  - `done` ← 1; `busy` ← 0; go to IDLE.
- Overflow: the scratch register holds only 4 digits, so bits above 9999 are discarded during shifting. The saturated 9999 is forced on `ovf`; the wrapped scratch value is never output.
- `start` while `busy`=1 is ignored: no queueing, and the in-flight conversion is undisturbed.
- `done` is high only in the cycle immediately after the completion edge; otherwise 0.
- `bcd` and `ovf` change only on the completion edge or on reset. They hold their values indefinitely in IDLE.
- Reset (any state, including mid-SHIFT) → IDLE. `bcd`=16'h0000, `busy`=0, `done`=0, `ovf`=0, `cnt`=0, scratch and shift registers = 0. The in-flight conversion is abandoned with no `done`.
- `rst` and `start` asserted in the same cycle: reset wins and `start` is dropped.

## Timing
- `start` sampled at edge E0 → `busy`=1 from E0 through E`WIDTH`.
- `done`=1 and the new `bcd`/`ovf` are valid in the cycle after edge E`WIDTH`. Latency is `WIDTH` cycles; 14 by default.
- `busy` falls in the same cycle that `done` rises.
- Back-to-back: `start` held high while `done`=1 is accepted at that edge, since `busy`=0. Maximum throughput is one conversion per `WIDTH`+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_DIGITS`=4;
  - `BCD_MAX`=9999;
  - `BCD_SAT`=16'h9999;
  - FSM state encoding (IDLE=1'b0, SHIFT=1'b1).
  The display block and this block both use it.
- One sub-module, `bcd_add3`: a combinational 4-bit "if ≥5 add 3" digit corrector, instantiated 4× in the SHIFT datapath.
- Top level holds the FSM, counter, shift/scratch registers and output registers. The whole block is about 150–200 lines.

## Test plan
- Reset, then `bin`=0 with `start` for 1 cycle → `done` pulses 14 cycles later, `bcd`=16'h0000, `ovf`=0.
- `bin`=4321, `start` pulse → `busy` high for exactly 14 cycles, then `bcd`=16'h4321 with a single-cycle `done`. `bcd` stays 16'h4321 for 50 idle cycles.
- `bin`=9999 → `bcd`=16'h9999, `ovf`=0. Then `bin`=10000 → `bcd`=16'h9999, `ovf`=1. Then `bin`=16383 → 16'h9999, `ovf`=1. Then `bin`=7 → 16'h0007, `ovf`=0.
- `start`(`bin`=1234), then `start`(`bin`=5678) pulsed 5 cycles later → the second request is ignored; result 16'h1234, exactly one `done`.
- `start`(`bin`=8765), `rst` asserted 6 cycles later for 1 cycle → no `done` ever. After reset, outputs are 0 and a new `start`(`bin`=42) gives 16'h0042 on schedule.
- `start` held continuously with `bin`=1, 2, 3 changed on each `done` → three results 16'h0001, 16'h0002, 16'h0003, each 15 cycles apart.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and FSM encoding for the BCD converter and display.
package bcd_pkg;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_MAX = 9999;
  localparam logic [15:0] BCD_SAT = 16'h9999;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit corrector, adds 3 to a digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd4.sv
// bin_to_bcd4: sequential shift-and-add-3 binary to 4-digit packed BCD converter.
module bin_to_bcd4
  import bcd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic [15:0]      bcd,
  output logic             busy,
  output logic             done,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(BCD_MAX);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [15:0] scr_q, scr_d, corr, bcd_q, bcd_d;
  logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, ovf_nx_q, ovf_nx_d;
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_dig
    bcd_add3 u_add3 (.d(scr_q[4*i +: 4]), .q(corr[4*i +: 4]));
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    scr_d = scr_q;
    bcd_d = bcd_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d = ovf_q;
    ovf_nx_d = ovf_nx_q;
    if (state_q == IDLE) begin
      if (start) begin
        sh_d = bin;
        scr_d = '0;
        cnt_d = CW'(WIDTH);
        ovf_nx_d = bin > MAX_W;
        busy_d = 1'b1;
        state_d = SHIFT;
      end
    end else begin
      // Bits shifted out of the top digit are dropped; overflow saturates below.
      {scr_d, sh_d} = {corr, sh_q} << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        bcd_d = ovf_nx_q ? BCD_SAT : scr_d;
        ovf_d = ovf_nx_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      scr_q <= '0;
      bcd_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      ovf_nx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      scr_q <= scr_d;
      bcd_q <= bcd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      ovf_nx_q <= ovf_nx_d;
    end
  end
  assign bcd = bcd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd4.sv
// tb_bin_to_bcd4: directed self-checking bench for bin_to_bcd4.
module tb_bin_to_bcd4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [13:0] bin = '0;
  logic [15:0] bcd;
  logic busy, done, ovf;
  int checks = 0;
  int failures = 0;

  bin_to_bcd4 #(.WIDTH(14)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .bcd(bcd), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat = 0;
    int bc = 0;
    start = 1'b1;
    bin = v;
    step();
    start = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (busy) bc++;
      step();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat != 14) begin
      failures++;
      $display("FAIL conv_latency bin=%0d got done=%b lat=%0d expected done=1 lat=14", v, done, lat);
    end
    checks++;
    if (bc != 14 || busy !== 1'b0) begin
      failures++;
      $display("FAIL conv_busy bin=%0d got busy_cycles=%0d busy=%b expected 14 and 0", v, bc, busy);
    end
    checks++;
    if (bcd !== exp_bcd || ovf !== exp_ovf) begin
      failures++;
      $display("FAIL conv_result bin=%0d got bcd=%h ovf=%b expected bcd=%h ovf=%b", v, bcd, ovf, exp_bcd, exp_ovf);
    end
    step();
    checks++;
    if (done !== 1'b0 || bcd !== exp_bcd) begin
      failures++;
      $display("FAIL conv_done_pulse bin=%0d got done=%b bcd=%h expected done=0 bcd=%h", v, done, bcd, exp_bcd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    bin = 14'd5;
    step();
    step();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if (bcd !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got bcd=%h busy=%b done=%b ovf=%b expected all 0", bcd, busy, done, ovf);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_start got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    convert(14'd0, 16'h0000, 1'b0);
    convert(14'd4321, 16'h4321, 1'b0);
  endtask

  task automatic test_hold();
    int bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (bcd !== 16'h4321 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_hold got %0d bad cycles expected 0 (bcd=%h)", bad, bcd);
    end
  endtask

  task automatic test_overflow();
    convert(14'd9999, 16'h9999, 1'b0);
    convert(14'd10000, 16'h9999, 1'b1);
    convert(14'd16383, 16'h9999, 1'b1);
    convert(14'd7, 16'h0007, 1'b0);
  endtask

  task automatic test_ignore_busy();
    int nd = 0;
    int t = 0;
    start = 1'b1;
    bin = 14'd1234;
    step();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 5);
      if (k == 5) bin = 14'd5678;
      step();
      if (done) begin
        nd++;
        t = k;
      end
    end
    start = 1'b0;
    checks++;
    if (nd != 1 || t != 14) begin
      failures++;
      $display("FAIL ignore_busy_done got count=%0d at=%0d expected count=1 at=14", nd, t);
    end
    checks++;
    if (bcd !== 16'h1234) begin
      failures++;
      $display("FAIL ignore_busy_result got bcd=%h expected 1234", bcd);
    end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    start = 1'b1;
    bin = 14'd8765;
    step();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      rst = (k == 6);
      step();
      if (done) nd++;
    end
    rst = 1'b0;
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got %0d done pulses expected 0", nd);
    end
    checks++;
    if (bcd !== 16'h0000 || busy !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got bcd=%h busy=%b ovf=%b expected 0", bcd, busy, ovf);
    end
    convert(14'd42, 16'h0042, 1'b0);
  endtask

  task automatic test_back_to_back();
    int times[3];
    logic [15:0] res[3];
    int n = 0;
    start = 1'b1;
    bin = 14'd1;
    step();
    for (int k = 1; k <= 80 && n < 3; k++) begin
      step();
      if (done) begin
        times[n] = k;
        res[n] = bcd;
        n++;
        bin = 14'(n + 1);
      end
    end
    start = 1'b0;
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL b2b_count got %0d results expected 3", n);
    end else begin
      checks++;
      if (res[0] !== 16'h0001 || res[1] !== 16'h0002 || res[2] !== 16'h0003) begin
        failures++;
        $display("FAIL b2b_values got %h %h %h expected 0001 0002 0003", res[0], res[1], res[2]);
      end
      checks++;
      if (times[0] != 14 || times[1] != 29 || times[2] != 44) begin
        failures++;
        $display("FAIL b2b_timing got %0d %0d %0d expected 14 29 44", times[0], times[1], times[2]);
      end
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
